card_draw_arbiter: RTL

Shares one free-running random-number source between the player and dealer draw paths of the blackjack game. Arbitrates draw requests round-robin, reduces the random value to a card index 0..51, and suppresses already-dealt cards so a shoe deals each card once. Sits between `randomNumberModule` and `statemachine`, replacing the two independent generators with one sequenced resource.

---
 rtl/card_draw_arbiter.sv | 229 ++++++++++++++++++++++
 1 files changed

// File: rtl/card_draw_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : card_draw_arbiter
// Description : Shares one free-running random source between the player and
//               dealer draw paths. Requests are arbitrated round-robin, the
//               random value is reduced to a card index 0..DECK_SIZE-1 and,
//               when CARD_DEDUP_EN is defined, already-dealt cards are skipped
//               by linear probing so a shoe deals every card exactly once.
//
// Build macro : CARD_DEDUP_EN
//               defined   - used-mask, PROBE state, cards_left countdown and
//                           empty-shoe path (card 63) are present
//               undefined - reduced index is dealt directly (duplicates
//                           allowed), cards_left fixed at DECK_SIZE, CLEAR is
//                           a one-cycle no-op
//
// Ports       : Clock       - system clock
//               reset_n     - synchronous active-low reset
//               rand_in     - free-running random value (sampled in SAMPLE)
//               p_req/d_req - player/dealer draw requests (level)
//               new_deck    - one-cycle pulse, returns all cards to the shoe
//               p_grant/d_grant - one-cycle grant pulses, card valid with them
//               card        - dealt index, 63 when the shoe is empty
//               card_value  - blackjack value of card (0 for 63)
//               cards_left  - cards remaining in the shoe
//               deck_empty  - cards_left == 0
//               busy        - FSM is outside IDLE
//
// Revision    : 1.0 - initial release
// ============================================================================
module card_draw_arbiter #(
    parameter int DECK_SIZE = 52,
    parameter int CARD_W    = 6
) (
    input  logic              Clock,
    input  logic              reset_n,
    input  logic [CARD_W-1:0] rand_in,
    input  logic              p_req,
    input  logic              d_req,
    input  logic              new_deck,
    output logic              p_grant,
    output logic              d_grant,
    output logic [CARD_W-1:0] card,
    output logic [4:0]        card_value,
    output logic [5:0]        cards_left,
    output logic              deck_empty,
    output logic              busy
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        CLEAR  = 3'd1,
        SAMPLE = 3'd2,
        PROBE  = 3'd3,
        GRANT  = 3'd4
    } state_t;

    localparam logic [CARD_W-1:0] c_deck  = CARD_W'(DECK_SIZE);
    localparam logic [CARD_W-1:0] c_empty = CARD_W'(63);
    localparam logic [5:0]        c_full  = 6'(DECK_SIZE);

    state_t            r_state;
    state_t            w_next;
    logic              r_nd_pending;    // new_deck seen while a draw was in flight
    logic              r_draw_pending;  // a draw was arbitrated together with a clear
    logic              r_last_dealer;   // 1: dealer was served last
    logic              r_win_dealer;    // winner of the current draw
    logic [CARD_W-1:0] r_result;        // card to present at the grant
    logic [CARD_W-1:0] w_reduced;
    logic              w_p_elig;
    logic              w_d_elig;
    logic              w_any_req;
    logic              w_pick_dealer;
    logic              w_nd;

    function automatic logic [4:0] f_value(input logic [CARD_W-1:0] c);
        logic [CARD_W-1:0] rank;
        rank = c % CARD_W'(13);
        if (c == c_empty)
            return 5'd0;
        else if (rank >= CARD_W'(9))
            return 5'd10;
        else
            return 5'(rank) + 5'd1;
    endfunction

    // A requester still holds its request during its own grant cycle (it drops
    // it one cycle later), so that request must not start a second draw.
    assign w_p_elig  = p_req & ~p_grant;
    assign w_d_elig  = d_req & ~d_grant;
    assign w_any_req = w_p_elig | w_d_elig;

    // Dealer wins when it asks alone, or on a tie when the player went last.
    assign w_pick_dealer = w_d_elig & (~w_p_elig | ~r_last_dealer);

    assign w_nd      = new_deck | r_nd_pending;

    // rand_in < 2*DECK_SIZE, so one conditional subtraction reaches 0..DECK_SIZE-1.
    assign w_reduced = (rand_in < c_deck) ? rand_in : rand_in - c_deck;

    assign busy       = (r_state != IDLE);
    assign deck_empty = (cards_left == 6'd0);

`ifdef CARD_DEDUP_EN
    logic [DECK_SIZE-1:0] r_used;
    logic [CARD_W-1:0]    r_idx;
    logic [CARD_W-1:0]    w_idx_next;
    logic                 w_hit;

    assign w_hit      = r_used[r_idx];
    assign w_idx_next = (r_idx == c_deck - CARD_W'(1)) ? '0 : r_idx + CARD_W'(1);
`else
    assign cards_left = c_full;
`endif

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!reset_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next = r_state;
        case (r_state)
            IDLE: begin
                if (w_nd)
                    w_next = CLEAR;
                else if (w_any_req)
                    w_next = SAMPLE;
            end
            // A draw arbitrated alongside the clear continues straight into
            // SAMPLE, so the clear costs a single cycle.
            CLEAR:  w_next = r_draw_pending ? SAMPLE : IDLE;
`ifdef CARD_DEDUP_EN
            SAMPLE: w_next = (cards_left == 6'd0) ? GRANT : PROBE;
            PROBE:  w_next = w_hit ? PROBE : GRANT;
`else
            SAMPLE: w_next = GRANT;
            PROBE:  w_next = GRANT;
`endif
            GRANT:  w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge Clock) begin
        if (!reset_n) begin
            p_grant        <= 1'b0;
            d_grant        <= 1'b0;
            card           <= '0;
            card_value     <= '0;
            r_nd_pending   <= 1'b0;
            r_draw_pending <= 1'b0;
            r_last_dealer  <= 1'b1;
            r_win_dealer   <= 1'b0;
            r_result       <= '0;
`ifdef CARD_DEDUP_EN
            r_used         <= '0;
            r_idx          <= '0;
            cards_left     <= c_full;
`endif
        end else begin
            p_grant <= 1'b0;
            d_grant <= 1'b0;

            // Clears requested mid-draw wait until the draw has completed.
            if (new_deck && (r_state != IDLE))
                r_nd_pending <= 1'b1;

            case (r_state)
                IDLE: begin
                    if (w_any_req)
                        r_win_dealer <= w_pick_dealer;
                    if (w_nd)
                        r_draw_pending <= w_any_req;
                end
                CLEAR: begin
                    // A new_deck pulse landing here is satisfied by this clear.
                    r_nd_pending   <= 1'b0;
                    r_draw_pending <= 1'b0;
`ifdef CARD_DEDUP_EN
                    r_used         <= '0;
                    cards_left     <= c_full;
`endif
                end
                SAMPLE: begin
`ifdef CARD_DEDUP_EN
                    r_idx <= w_reduced;
                    if (cards_left == 6'd0)
                        r_result <= c_empty;
`else
                    r_result <= w_reduced;
`endif
                end
`ifdef CARD_DEDUP_EN
                PROBE: begin
                    if (w_hit) begin
                        r_idx <= w_idx_next;
                    end else begin
                        r_used[r_idx] <= 1'b1;
                        cards_left    <= cards_left - 6'd1;
                        r_result      <= r_idx;
                    end
                end
`endif
                GRANT: begin
                    p_grant       <= ~r_win_dealer;
                    d_grant       <= r_win_dealer;
                    r_last_dealer <= r_win_dealer;
                    card          <= r_result;
                    card_value    <= f_value(r_result);
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire
